// File: rtl/mux_pkg.sv
// Shared constants for the 8->32 byte packer: lane/word widths and collector states.
package mux_pkg;
    localparam int LANE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = LANE_W * BYTES_PER_WORD;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;
endpackage

// File: rtl/mux_idle_timer.sv
// Counts consecutive idle cycles of a partial word; expire_o flags the TIMEOUT-th idle edge.
// Combinational expire, no backpressure; only built when MUX_TIMEOUT_EN is defined.
module mux_idle_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk_4f,
    input  logic reset_L,
    input  logic run_i,
    output logic expire_o
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] idle_q;
    logic [TMR_W-1:0] idle_d;

    assign expire_o = run_i && (idle_q == TMR_W'(TIMEOUT - 1));

    // Any non-idle cycle (byte accepted or nothing held) restarts the count.
    always_comb begin
        idle_d = '0;
        if (run_i && !expire_o) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
endmodule

// File: rtl/mux8_32.sv
// Packs accepted bytes MSB-first into 32-bit words; word + valid_out registered 1 clk after 4th byte.
// No backpressure: a byte is taken on every edge with valid_in=1. MUX_TIMEOUT_EN adds partial-word drop.
module mux8_32
    import mux_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic [LANE_W-1:0] data_in,
    input  logic              valid_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              busy,
    output logic              drop
);
    localparam int HOLD_W = WORD_W - LANE_W;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  data_out_q, data_out_d;
    logic               valid_out_q, valid_out_d;
    logic               drop_q, drop_d;
    logic               timeout_hit;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mux8_32: TIMEOUT must be at least 1");
    end

`ifdef MUX_TIMEOUT_EN
    mux_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk_4f   (clk_4f),
        .reset_L  (reset_L),
        .run_i    ((state_q == COLLECT) && !valid_in),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Earlier bytes shift up through word_q so the first byte lands in the top lane.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        drop_d      = 1'b0;
        if (valid_in) begin
            if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                data_out_d  = {word_q, data_in};
                valid_out_d = 1'b1;
                cnt_d       = '0;
                state_d     = IDLE;
            end else begin
                word_d  = {word_q[HOLD_W-LANE_W-1:0], data_in};
                cnt_d   = cnt_q + 1'b1;
                state_d = COLLECT;
            end
        end else if (timeout_hit) begin
            cnt_d   = '0;
            state_d = IDLE;
            drop_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            drop_q      <= drop_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign busy      = (state_q == COLLECT);
`ifdef MUX_TIMEOUT_EN
    assign drop      = drop_q;
`else
    assign drop      = 1'b0;
`endif
endmodule

// File: tb/tb_mux8_32.sv
// Self-checking bench for mux8_32: directed vector table, reset/timeout sequences, random vs queue model.
module tb_mux8_32;
    localparam int TMO = 8;

    logic        clk_4f = 1'b0;
    logic        reset_L;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        busy;
    logic        drop;

    mux8_32 #(.TIMEOUT(TMO)) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk_4f = ~clk_4f;

    int n_checks = 0;
    int n_pass   = 0;
    int drop_cnt = 0;
    bit seen_stale = 0;

    // Reference model: bytes held so far, last word, pulses expected after the edge.
    logic [7:0]  mq[$];
    logic [31:0] m_data;
    logic        m_vo;
    logic        m_drop;
    int          m_idle;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        exp_vo;
        logic [31:0] exp_do;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[21];

    always @(posedge clk_4f) begin
        if (data_out === 32'hAABBCCDD) seen_stale = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = 32'h0;
        m_vo   = 1'b0;
        m_drop = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        m_vo   = 1'b0;
        m_drop = 1'b0;
        if (v) begin
            mq.push_back(d);
            m_idle = 0;
            if (mq.size() == 4) begin
                m_data = {mq[0], mq[1], mq[2], mq[3]};
                m_vo   = 1'b1;
                mq.delete();
            end
        end
`ifdef MUX_TIMEOUT_EN
        else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                mq.delete();
                m_idle = 0;
                m_drop = 1'b1;
            end
        end
`endif
    endtask

    task automatic step(input logic v, input logic [7:0] d, input bit cmp);
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        #1;
        model_step(v, d);
        if (drop === 1'b1) drop_cnt++;
        if (cmp) begin
            chk("valid_out", valid_out, m_vo);
            chk("data_out",  data_out,  m_data);
            chk("busy",      busy,      mq.size() > 0);
            chk("drop",      drop,      m_drop);
        end
    endtask

    task automatic set_vec(input int i, input logic v, input logic [7:0] d,
                           input logic vo, input logic [31:0] dout, input logic bz);
        vecs[i] = '{v: v, d: d, exp_vo: vo, exp_do: dout, exp_busy: bz};
    endtask

    initial begin
        set_vec( 0, 1, 8'h2E, 0, 32'h0,        1);
        set_vec( 1, 1, 8'h9F, 0, 32'h0,        1);
        set_vec( 2, 1, 8'h13, 0, 32'h0,        1);
        set_vec( 3, 1, 8'h05, 1, 32'h2E9F1305, 0);
        set_vec( 4, 0, 8'hFF, 0, 32'h2E9F1305, 0);
        set_vec( 5, 1, 8'h2E, 0, 32'h2E9F1305, 1);
        set_vec( 6, 1, 8'h9F, 0, 32'h2E9F1305, 1);
        set_vec( 7, 0, 8'hAA, 0, 32'h2E9F1305, 1);
        set_vec( 8, 0, 8'hBB, 0, 32'h2E9F1305, 1);
        set_vec( 9, 1, 8'h13, 0, 32'h2E9F1305, 1);
        set_vec(10, 1, 8'h05, 1, 32'h2E9F1305, 0);
        set_vec(11, 0, 8'h00, 0, 32'h2E9F1305, 0);
        for (int i = 0; i < 8; i++) begin
            set_vec(12 + i, 1, 8'(i + 1), 0, (i < 4) ? 32'h0 : 32'h01020304, 1);
        end
        vecs[12].exp_do = 32'h2E9F1305;
        vecs[13].exp_do = 32'h2E9F1305;
        vecs[14].exp_do = 32'h2E9F1305;
        set_vec(15, 1, 8'h04, 1, 32'h01020304, 0);
        set_vec(19, 1, 8'h08, 1, 32'h05060708, 0);
        set_vec(20, 0, 8'h00, 0, 32'h05060708, 0);

        // Reset state, checked while reset is held with the clock running.
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        model_reset();
        #23;
        chk("rst_data_out",  data_out,  32'h0);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_drop",      drop,      1'b0);
        @(negedge clk_4f);
        reset_L = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].v, vecs[i].d, 1'b0);
            chk($sformatf("vec%0d_valid_out", i), valid_out, vecs[i].exp_vo);
            chk($sformatf("vec%0d_data_out", i),  data_out,  vecs[i].exp_do);
            chk($sformatf("vec%0d_busy", i),      busy,      vecs[i].exp_busy);
        end

        // Reset mid-word: the three held bytes must vanish without any pulse.
        step(1, 8'hAA, 1'b1);
        step(1, 8'hBB, 1'b1);
        step(1, 8'hCC, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_rst_data_out", data_out,  32'h0);
        chk("async_rst_busy",     busy,      1'b0);
        chk("async_rst_valid",    valid_out, 1'b0);
        model_reset();
        @(negedge clk_4f);
        chk("rst_hold_valid", valid_out, 1'b0);
        chk("rst_hold_drop",  drop,      1'b0);
        @(negedge clk_4f);
        reset_L = 1'b1;
        step(1, 8'hDD, 1'b1);
        step(1, 8'h11, 1'b1);
        step(1, 8'h22, 1'b1);
        step(1, 8'h33, 1'b1);
        chk("post_rst_word", data_out, 32'hDD112233);
        chk("no_stale_word", 32'(seen_stale), 32'h0);

        // Idle-timeout sequence: one byte then TMO idle cycles.
        drop_cnt = 0;
        step(1, 8'h55, 1'b1);
        for (int i = 0; i < TMO; i++) step(0, 8'($urandom), 1'b1);
`ifdef MUX_TIMEOUT_EN
        chk("timeout_drop_count", drop_cnt, 1);
        chk("timeout_busy",       busy,     1'b0);
        step(0, 8'h00, 1'b1);
        chk("drop_one_cycle",     drop,     1'b0);
`else
        chk("no_timeout_drop",    drop_cnt, 0);
        chk("hold_partial_busy",  busy,     1'b1);
`endif
        step(1, 8'h01, 1'b1);
        step(1, 8'h02, 1'b1);
        step(1, 8'h03, 1'b1);
        step(1, 8'h04, 1'b1);
`ifdef MUX_TIMEOUT_EN
        chk("after_timeout_word", data_out, 32'h01020304);
`else
        chk("held_partial_word",  data_out, 32'h55010203);
`endif

        // Random traffic, with occasional long gaps to reach the timeout.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                for (int j = 0; j < TMO + 1; j++) step(0, 8'($urandom), 1'b1);
            end else begin
                step($urandom_range(0, 9) < 6, 8'($urandom), 1'b1);
            end
        end
        step(0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
